// File: rtl/vga_pkg.sv
// Shared constants and colour helpers for the VGA sprite engine.
// Default timing is 640x480 at 60 Hz from a 100 MHz clock.
package vga_pkg;

    localparam int   COORD_W          = 10;

    localparam int   DEF_CLK_DIV      = 4;
    localparam int   DEF_H_ACTIVE     = 640;
    localparam int   DEF_H_FP         = 16;
    localparam int   DEF_H_SYNC       = 96;
    localparam int   DEF_H_BP         = 48;
    localparam int   DEF_V_ACTIVE     = 480;
    localparam int   DEF_V_FP         = 10;
    localparam int   DEF_V_SYNC       = 2;
    localparam int   DEF_V_BP         = 29;
    localparam int   DEF_NUM_SPRITES  = 3;
    localparam int   DEF_RADIUS       = 15;
    localparam logic DEF_SYNC_POL     = 1'b0;

    localparam int   RGB_R_LSB        = 0;
    localparam int   RGB_R_W          = 3;
    localparam int   RGB_G_LSB        = 3;
    localparam int   RGB_G_W          = 3;
    localparam int   RGB_B_LSB        = 6;
    localparam int   RGB_B_W          = 2;

    typedef struct packed {
        logic [RGB_B_W-1:0] b;
        logic [RGB_G_W-1:0] g;
        logic [RGB_R_W-1:0] r;
    } rgb332_t;

    function automatic rgb332_t rgb_unpack(input logic [7:0] v);
        rgb332_t c;
        c.r = v[RGB_R_LSB +: RGB_R_W];
        c.g = v[RGB_G_LSB +: RGB_G_W];
        c.b = v[RGB_B_LSB +: RGB_B_W];
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, raster counters, raw sync and active flags.
// Active area comes first, so counter values are active coordinates.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_pix_en,
    output logic [COORD_W-1:0] o_hc,
    output logic [COORD_W-1:0] o_vc,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_active,
    output logic               o_frame_start
);

    localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] HC_LAST  = COORD_W'(HT - 1);
    localparam logic [COORD_W-1:0] VC_LAST  = COORD_W'(VT - 1);
    localparam logic [COORD_W-1:0] HA       = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] VA       = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]   r_div;
    logic [COORD_W-1:0] r_hc;
    logic [COORD_W-1:0] r_vc;
    logic               w_pix_en;

    assign w_pix_en = (r_div == DIV_LAST);

    // Free-running clock divider producing one pix_en per CLK_DIV clocks
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= '0;
        end else if (w_pix_en) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Horizontal and vertical raster counters, advanced on pix_en
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_pix_en) begin
            if (r_hc == HC_LAST) begin
                r_hc <= '0;
                r_vc <= (r_vc == VC_LAST) ? '0 : r_vc + 1'b1;
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    assign o_pix_en      = w_pix_en;
    assign o_hc          = r_hc;
    assign o_vc          = r_vc;
    assign o_active      = (r_hc < HA) && (r_vc < VA);
    assign o_hsync       = (r_hc >= HS_BEG && r_hc < HS_END) ? SYNC_POL : ~SYNC_POL;
    assign o_vsync       = (r_vc >= VS_BEG && r_vc < VS_END) ? SYNC_POL : ~SYNC_POL;
    assign o_frame_start = w_pix_en && (r_hc == '0) && (r_vc == VA);

endmodule

// File: rtl/vga_sprite_engine.sv
// Circle sprite renderer over VGA timing with per-frame collision flags.
// Sprite state is latched at the start of vblank so frames never tear.
module vga_sprite_engine
    import vga_pkg::*;
#(
    parameter int   CLK_DIV     = DEF_CLK_DIV,
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter int   NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int   RADIUS      = DEF_RADIUS,
    parameter logic SYNC_POL    = DEF_SYNC_POL
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic [COORD_W*NUM_SPRITES-1:0] sprite_x,
    input  logic [COORD_W*NUM_SPRITES-1:0] sprite_y,
    input  logic [8*NUM_SPRITES-1:0]       sprite_rgb,
    input  logic [NUM_SPRITES-1:0]         sprite_en,
    input  logic [7:0]                     bg_rgb,
    output logic                           hsync,
    output logic                           vsync,
    output logic [2:0]                     red,
    output logic [2:0]                     green,
    output logic [1:0]                     blue,
    output logic                           de,
    output logic                           frame_start,
    output logic [NUM_SPRITES-1:0]         collide
);

    localparam int SQ_W = 2 * COORD_W + 1;
    localparam logic [SQ_W-1:0] R2 = SQ_W'(RADIUS * RADIUS);

    logic               w_pix_en;
    logic [COORD_W-1:0] w_hc;
    logic [COORD_W-1:0] w_vc;
    logic               w_hs_raw;
    logic               w_vs_raw;
    logic               w_act_raw;
    logic               w_frame_start;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .i_clk         (clk),
        .i_rst_n       (clr),
        .o_pix_en      (w_pix_en),
        .o_hc          (w_hc),
        .o_vc          (w_vc),
        .o_hsync       (w_hs_raw),
        .o_vsync       (w_vs_raw),
        .o_active      (w_act_raw),
        .o_frame_start (w_frame_start)
    );

    assign frame_start = w_frame_start;

    logic [COORD_W-1:0]     r_sx  [NUM_SPRITES];
    logic [COORD_W-1:0]     r_sy  [NUM_SPRITES];
    logic [7:0]             r_rgb [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] r_en;

    // Shadow copy of sprite inputs, taken once per frame at vblank start
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_sx[i]  <= '0;
                r_sy[i]  <= '0;
                r_rgb[i] <= '0;
            end
            r_en <= '0;
        end else if (w_frame_start) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_sx[i]  <= sprite_x[COORD_W*i +: COORD_W];
                r_sy[i]  <= sprite_y[COORD_W*i +: COORD_W];
                r_rgb[i] <= sprite_rgb[8*i +: 8];
            end
            r_en <= sprite_en;
        end
    end

    logic [NUM_SPRITES-1:0] w_hit;

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
        logic signed [COORD_W:0] w_ddx;
        logic signed [COORD_W:0] w_ddy;
        logic [COORD_W:0]        r_dx;
        logic [COORD_W:0]        r_dy;
        logic [SQ_W-1:0]         w_sq;

        assign w_ddx = $signed({1'b0, w_hc}) - $signed({1'b0, r_sx[g]});
        assign w_ddy = $signed({1'b0, w_vc}) - $signed({1'b0, r_sy[g]});

        // Stage 1: absolute distance from the sprite centre, no wrap
        always_ff @(posedge clk or negedge clr) begin
            if (!clr) begin
                r_dx <= '0;
                r_dy <= '0;
            end else if (w_pix_en) begin
                r_dx <= w_ddx[COORD_W] ? $unsigned(-w_ddx) : $unsigned(w_ddx);
                r_dy <= w_ddy[COORD_W] ? $unsigned(-w_ddy) : $unsigned(w_ddy);
            end
        end

        assign w_sq = {{COORD_W{1'b0}}, r_dx} * {{COORD_W{1'b0}}, r_dx}
                    + {{COORD_W{1'b0}}, r_dy} * {{COORD_W{1'b0}}, r_dy};
        assign w_hit[g] = r_en[g] && (w_sq < R2);
    end

    logic       r_hs1;
    logic       r_vs1;
    logic       r_act1;
    logic [7:0] w_col;
    rgb332_t    w_px;
    logic       w_multi;

    // Stage 1 delay of sync and active alongside the distance registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_hs1  <= ~SYNC_POL;
            r_vs1  <= ~SYNC_POL;
            r_act1 <= 1'b0;
        end else if (w_pix_en) begin
            r_hs1  <= w_hs_raw;
            r_vs1  <= w_vs_raw;
            r_act1 <= w_act_raw;
        end
    end

    // Lowest-index hit sprite wins, background otherwise
    always_comb begin
        w_col = bg_rgb;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_col = r_rgb[i];
            end
        end
    end

    assign w_px    = rgb_unpack(w_col);
    assign w_multi = (w_hit & (w_hit - NUM_SPRITES'(1))) != '0;

    // Stage 2: registered pixel colour, blanking and delayed syncs
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            de    <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (w_pix_en) begin
            hsync <= r_hs1;
            vsync <= r_vs1;
            de    <= r_act1;
            red   <= r_act1 ? w_px.r : '0;
            green <= r_act1 ? w_px.g : '0;
            blue  <= r_act1 ? w_px.b : '0;
        end
    end

    logic [NUM_SPRITES-1:0] r_acc;

    // Overlaps on visible pixels accumulate; published at vblank start
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_acc   <= '0;
            collide <= '0;
        end else if (w_frame_start) begin
            collide <= r_acc;
            r_acc   <= '0;
        end else if (w_pix_en && r_act1 && w_multi) begin
            r_acc <= r_acc | w_hit;
        end
    end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine on a reduced 80x54 raster.
// Expected pixels and times are computed by hand from the raster layout.
module tb_vga_sprite_engine;

    localparam int NS = 3;
    localparam int D  = 2;
    localparam int HT = 80;
    localparam int VT = 54;
    localparam int FT = D * HT * VT;
    localparam int FS = D * 48 * HT + D - 1;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic [10*NS-1:0] sprite_x;
    logic [10*NS-1:0] sprite_y;
    logic [8*NS-1:0]  sprite_rgb;
    logic [NS-1:0]    sprite_en;
    logic [7:0]    bg_rgb;
    logic          hsync;
    logic          vsync;
    logic [2:0]    red;
    logic [2:0]    green;
    logic [1:0]    blue;
    logic          de;
    logic          frame_start;
    logic [NS-1:0] collide;

    int cyc;
    int checks;
    int errors;

    always #5 clk = ~clk;

    vga_sprite_engine #(
        .CLK_DIV     (D),
        .H_ACTIVE    (64),
        .H_FP        (4),
        .H_SYNC      (8),
        .H_BP        (4),
        .V_ACTIVE    (48),
        .V_FP        (2),
        .V_SYNC      (2),
        .V_BP        (2),
        .NUM_SPRITES (NS),
        .RADIUS      (4),
        .SYNC_POL    (1'b0)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .sprite_rgb  (sprite_rgb),
        .sprite_en   (sprite_en),
        .bg_rgb      (bg_rgb),
        .hsync       (hsync),
        .vsync       (vsync),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .de          (de),
        .frame_start (frame_start),
        .collide     (collide)
    );

    always @(posedge clk or negedge clr) begin
        if (!clr) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
        if (cyc != t) begin
            errors++;
            $error("FAIL goto: observed %0d expected %0d", cyc, t);
        end
    endtask

    function automatic int pc(input int f, input int x, input int y);
        return f * FT + D * (y * HT + x + 2);
    endfunction

    task automatic pix(input string tag, input int f, input int x,
                       input int y, input logic [7:0] exp_rgb,
                       input logic exp_de);
        goto(pc(f, x, y));
        check({tag, "_rgb"}, {24'd0, blue, green, red}, {24'd0, exp_rgb});
        check({tag, "_de"}, {31'd0, de}, {31'd0, exp_de});
    endtask

    task automatic set_spr(input int i, input int x, input int y,
                           input logic [7:0] c, input logic en);
        sprite_x[10*i +: 10]  = 10'(x);
        sprite_y[10*i +: 10]  = 10'(y);
        sprite_rgb[8*i +: 8]  = c;
        sprite_en[i]          = en;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_rgb"}, {24'd0, blue, green, red}, 32'd0);
        check({tag, "_de"}, {31'd0, de}, 32'd0);
        check({tag, "_hs"}, {31'd0, hsync}, 32'd1);
        check({tag, "_vs"}, {31'd0, vsync}, 32'd1);
        check({tag, "_fs"}, {31'd0, frame_start}, 32'd0);
        check({tag, "_col"}, {29'd0, collide}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sprite_x = '0;
        sprite_y = '0;
        sprite_rgb = '0;
        sprite_en = '0;
        bg_rgb = 8'h49;
        set_spr(0, 20, 20, 8'hFF, 1'b1);
        set_spr(1, 1022, 40, 8'h07, 1'b1);
        set_spr(2, 2, 2, 8'h38, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");

        @(negedge clk);
        clr = 1'b1;
        goto(139); check("hs_pre", {31'd0, hsync}, 32'd1);
        goto(140); check("hs_on", {31'd0, hsync}, 32'd0);
        goto(155); check("hs_last", {31'd0, hsync}, 32'd0);
        goto(156); check("hs_off", {31'd0, hsync}, 32'd1);
        goto(300); check("hs_next", {31'd0, hsync}, 32'd0);

        pix("f0_bg", 0, 20, 20, 8'h49, 1'b1);

        goto(FS - 1); check("fs0_pre", {31'd0, frame_start}, 32'd0);
        goto(FS);     check("fs0", {31'd0, frame_start}, 32'd1);
        goto(FS + 1); check("fs0_post", {31'd0, frame_start}, 32'd0);
        goto(FS + 2); check("col0", {29'd0, collide}, 32'd0);

        goto(8003); check("vs_pre", {31'd0, vsync}, 32'd1);
        goto(8004); check("vs_on", {31'd0, vsync}, 32'd0);
        goto(8323); check("vs_last", {31'd0, vsync}, 32'd0);
        goto(8324); check("vs_off", {31'd0, vsync}, 32'd1);

        pix("f1_edge", 1, 0, 2, 8'h38, 1'b1);

        set_spr(0, 40, 20, 8'hFF, 1'b1);
        set_spr(1, 44, 20, 8'h07, 1'b1);
        set_spr(2, 42, 24, 8'h38, 1'b0);

        pix("f1_ctr", 1, 20, 20, 8'hFF, 1'b1);
        pix("f1_r3", 1, 23, 20, 8'hFF, 1'b1);
        pix("f1_r4", 1, 24, 20, 8'h49, 1'b1);
        pix("f1_s1old", 1, 45, 20, 8'h49, 1'b1);
        pix("f1_hblank", 1, 70, 20, 8'h00, 1'b0);
        pix("f1_diag_in", 1, 22, 23, 8'hFF, 1'b1);
        pix("f1_diag_out", 1, 23, 23, 8'h49, 1'b1);
        pix("f1_nowrap", 1, 0, 40, 8'h49, 1'b1);

        goto(FT + FS);     check("fs1", {31'd0, frame_start}, 32'd1);
        goto(FT + FS + 2); check("col1", {29'd0, collide}, 32'd0);

        pix("f1_vblank", 1, 20, 50, 8'h00, 1'b0);

        pix("f2_moved", 2, 20, 20, 8'h49, 1'b1);
        pix("f2_prio", 2, 42, 20, 8'hFF, 1'b1);
        pix("f2_s1", 2, 45, 20, 8'h07, 1'b1);
        pix("f2_dis", 2, 42, 27, 8'h49, 1'b1);

        goto(2 * FT + FS);     check("fs2", {31'd0, frame_start}, 32'd1);
        goto(2 * FT + FS + 2); check("col2", {29'd0, collide}, 32'd3);

        pix("f3_hold", 3, 42, 20, 8'hFF, 1'b1);

        @(negedge clk);
        clr = 1'b0;
        #1;
        chk_reset("async");

        repeat (5) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        goto(139); check("r2_hs_pre", {31'd0, hsync}, 32'd1);
        goto(140); check("r2_hs_on", {31'd0, hsync}, 32'd0);
        pix("r2_f0_bg", 0, 42, 20, 8'h49, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sprite_engine.md
Name: vga_sprite_engine

Overview:
- Parametrised successor of the 640x480 VGA timing/dot renderer.
- Generates VGA timing from a single system clock using an internal pixel-enable divider.
- Renders NUM_SPRITES filled circles, each with its own colour, over a background colour.
- Positions are latched once per frame, so there is no tearing. Per-sprite collision flags are reported each frame for the game logic (paddles/puck).

Parameters:
- CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz); must be >= 2
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, hsync pulse width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vsync pulse width, in lines
- V_BP, 29, vertical back porch, in lines
- NUM_SPRITES, 3, number of circle sprites (1..8)
- RADIUS, 15, circle radius in pixels; inside test is dx^2+dy^2 < RADIUS^2
- SYNC_POL, 0, active level of hsync/vsync

Ports:
- clk  in  1  system clock
- clr  in  1  reset: asynchronous assert, active-low
- sprite_x  in  10*NUM_SPRITES  centre x of each sprite in active-area coordinates; sprite i occupies bits [10i+9:10i]
- sprite_y  in  10*NUM_SPRITES  centre y of each sprite, same packing
- sprite_rgb  in  8*NUM_SPRITES  colour of each sprite, packed {blue[1:0],green[2:0],red[2:0]}
- sprite_en  in  NUM_SPRITES  per-sprite visibility enable
- bg_rgb  in  8  background colour inside the active area, same packing
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- red  out  3  red output
- green  out  3  green output
- blue  out  2  blue output
- de  out  1  high while a visible pixel is on the outputs
- frame_start  out  1  one-clk pulse at the first pix_en of vblank
- collide  out  NUM_SPRITES  bit i set if sprite i overlapped any other enabled sprite during the last completed frame

Behaviour:
- Divider: div_cnt counts 0..CLK_DIV-1. pix_en is high for one clk when div_cnt==CLK_DIV-1. All pixel logic advances only on pix_en.
- Counters:
  - HT = H_ACTIVE+H_FP+H_SYNC+H_BP and VT is the vertical equivalent; defaults give 800 and 521.
  - hc counts 0..HT-1. When hc wraps, vc increments; vc wraps at VT-1.
  - Pixel (hc,vc) is active iff hc<H_ACTIVE and vc<V_ACTIVE. Active area comes first, so active coordinates equal the counter values.
  - Raw sync is asserted at SYNC_POL for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and likewise for vc.
- Position latch: on the pix_en where hc==0 and vc==V_ACTIVE (the start of vblank):
  - sprite_x, sprite_y, sprite_rgb and sprite_en are copied into shadow registers. Rendering uses only the shadow registers.
  - frame_start pulses in the same cycle.
  - The collision accumulator is copied to collide and then cleared.
- Pipeline: 2 pix_en ticks of latency.
  - Stage 1: dx_i=|hc-sx_i| and dy_i=|vc-sy_i|, 11-bit signed difference then absolute value, so sprites near the edge are clipped, not wrapped.
  - Stage 2: hit_i = en_i && dx_i^2+dy_i^2 < RADIUS^2, computed at 21-bit width with no truncation. Colour priority: lowest-index hit wins, otherwise bg_rgb. The result registers into red/green/blue.
  - hsync, vsync and active are delayed by the same 2 ticks. Outputs hold between pix_en pulses.
- Blanking: when the delayed active signal is 0, red/green/blue are all 0 and de=0.
- Collision: for each active pixel with two or more hits, OR the hit vector into the accumulator. Overlap in blanking is ignored because circles clipped outside the active area do not count.
- Reset (clr low):
  - div_cnt, hc and vc are 0; the shadow registers are 0 and disabled.
  - red/green/blue are 0, de=0, frame_start=0, collide=0.
  - hsync and vsync are driven to the inactive level (~SYNC_POL).
  - Reset released mid-frame restarts timing from (0,0). The first frame after reset shows only background, because nothing is latched until the first vblank.
- Inputs may change at any time; only the value present at the latch tick matters.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants;
  - the RGB332 field-slice constants;
  - a function packing/unpacking the 8-bit colour;
  - the COORD_W=10 constant.
- One sub-module is natural: vga_timing (divider, hc/vc, raw sync, active, pix_en, frame_start).
- The sprite pipeline and collision logic stay in the top level, instantiated with a generate loop over NUM_SPRITES.

Test Plan:
- Reset then free-run, CLK_DIV=4 -> hsync period 3200 clk with a low pulse of 384 clk; vsync period 1,667,200 clk with a low pulse of 2 lines (6400 clk); frame_start once per frame.
- Sprite0 at (100,100) with colour 8'hFF, bg 8'h00 -> pixel (100,100) white; (114,100) white; (115,100) black; (110,111) white (221<225); output appears 2 pix_en after the counter reaches that pixel.
- Sprites 0 and 1 both at (200,200), colours 8'h07 and 8'h38 -> red=7/green=0 at the centre (index 0 wins); collide=2'b11 after the next frame_start.
- Sprites 600 px apart -> collide=0. Move sprite_x mid-frame -> the displayed position changes only after the next vblank latch.
- Sprite at (5,5) -> column 0 pixels drawn, no wrap to x=1019; sprite_en=0 -> never drawn and never collides.
- Assert clr mid-line -> all outputs at reset values immediately (async); after release, hsync first asserts at clk 4*(656)+pipeline.
